argmax_layer: RTL and testbench

- Final classification stage; sits directly downstream of the last dense layer and consumes its `outputs` array and `output_ready` flag.
- Captures the score vector and scans it sequentially, one element per clock, with a single signed comparator.
- Reports the index and value of the largest score with a level ready flag, plus a busy indicator.

---
 rtl/nn_pkg.sv | 21 ++
 rtl/argmax_layer.sv | 155 +++++++++++++++
 tb/tb_argmax_layer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for layer-level blocks of the inference pipeline:
// the common layer FSM state type and an index-width helper.
package nn_pkg;

  // Layer-level control states, shared by any layer FSM that captures a
  // vector, works on it for a while and then presents a result.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } layer_state_e;

  // Width needed to address n items. A single item still needs one bit so
  // that index ports never collapse to zero width.
  function automatic int index_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/argmax_layer.sv
// Final classification stage. Captures the score vector from the last dense
// layer, scans it one element per clock with a single signed comparator, and
// reports the index and value of the largest score. Ties resolve to the
// lowest index because only a strictly greater score replaces the best.
module argmax_layer
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_INPUTS  = 10,
  localparam int INDEX_WIDTH = index_width(NUM_INPUTS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         input_ready,
  input  logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
  output logic        [INDEX_WIDTH-1:0] index,
  output logic signed [DATA_WIDTH-1:0] max_value,
  output logic                         output_ready,
  output logic                         busy
);

  // Last position visited by the scan; reaching it finishes the vector.
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);
  // Element 0 seeds the best value on capture, so scanning starts at 1. A
  // one-element build never scans, and the counter stays at 0.
  localparam logic [INDEX_WIDTH-1:0] FIRST_SCAN_IDX =
    (NUM_INPUTS > 1) ? INDEX_WIDTH'(1) : INDEX_WIDTH'(0);

  layer_state_e                 state_q, state_d;
  logic        [INDEX_WIDTH-1:0] counter_q, counter_d;
  logic signed [DATA_WIDTH-1:0]  best_value_q, best_value_d;
  logic        [INDEX_WIDTH-1:0] best_index_q, best_index_d;
  logic        [INDEX_WIDTH-1:0] index_q, index_d;
  logic signed [DATA_WIDTH-1:0]  max_value_q, max_value_d;

  // Private copy of the score vector so upstream changes during the scan
  // cannot disturb the result.
  logic signed [DATA_WIDTH-1:0]  captured_q [NUM_INPUTS];
  logic                          capture_en;

  logic signed [DATA_WIDTH-1:0]  scan_value;
  logic                          scan_greater;

  // Select the element under the scan counter and compare it with the best
  // so far; both operands are signed so the compare is two's complement.
  always_comb begin
    scan_value = captured_q[0];
    for (int i = 1; i < NUM_INPUTS; i++) begin
      if (counter_q == INDEX_WIDTH'(i)) begin
        scan_value = captured_q[i];
      end
    end
    scan_greater = (scan_value > best_value_q);
  end

  // Next-state logic for the capture / scan / report sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    counter_d    = counter_q;
    best_value_d = best_value_q;
    best_index_d = best_index_q;
    index_d      = index_q;
    max_value_d  = max_value_q;
    capture_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (input_ready) begin
          capture_en   = 1'b1;
          best_value_d = inputs[0];
          best_index_d = '0;
          counter_d    = FIRST_SCAN_IDX;
          if (NUM_INPUTS == 1) begin
            // Nothing to scan: the only score is the result.
            state_d     = DONE;
            index_d     = '0;
            max_value_d = inputs[0];
          end else begin
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        if (scan_greater) begin
          best_value_d = scan_value;
          best_index_d = counter_q;
        end
        if (counter_q == LAST_IDX) begin
          // The final comparison lands in the outputs on the same edge.
          state_d     = DONE;
          index_d     = best_index_d;
          max_value_d = best_value_d;
        end else begin
          counter_d = counter_q + INDEX_WIDTH'(1);
        end
      end

      DONE: begin
        // The upstream flag is a level; only its release re-arms capture.
        if (!input_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, scan bookkeeping and registered result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      best_value_q <= '0;
      best_index_q <= '0;
      index_q      <= '0;
      max_value_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      counter_q    <= counter_d;
      best_value_q <= best_value_d;
      best_index_q <= best_index_d;
      index_q      <= index_d;
      max_value_q  <= max_value_d;
    end
  end

  // Capture register bank, loaded once per accepted vector.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: this storage is reset on purpose so a discarded vector leaves
      // no trace; storage that needs no defined start value would skip it.
      for (int i = 0; i < NUM_INPUTS; i++) begin
        captured_q[i] <= '0;
      end
    end else if (capture_en) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        captured_q[i] <= inputs[i];
      end
    end
  end

  assign index        = index_q;
  assign max_value    = max_value_q;
  assign output_ready = (state_q == DONE);
  assign busy         = (state_q == SCAN);

endmodule

// File: tb/tb_argmax_layer.sv
// Self-checking bench for argmax_layer: a ten-input build and a one-input
// build run side by side against a transaction-level argmax model.
module tb_argmax_layer;

  localparam int DW = 32;
  localparam int N  = 10;

  typedef logic signed [DW-1:0] score_arr_t [N];

  // Model view of one instance: edges left until the result appears, the
  // flags it must show, and the result it must hold.
  typedef struct {
    int                   remaining;
    bit                   ready;
    bit                   busy;
    int                   idx;
    logic signed [DW-1:0] val;
    int                   pend_idx;
    logic signed [DW-1:0] pend_val;
  } model_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ir10  = 1'b0;
  logic ir1   = 1'b0;

  score_arr_t           in10;
  logic signed [DW-1:0] in1 [1];
  score_arr_t           in1_ext;

  logic        [3:0]    idx10;
  logic signed [DW-1:0] val10;
  logic                 rdy10, busy10;
  logic        [0:0]    idx1;
  logic signed [DW-1:0] val1;
  logic                 rdy1, busy1;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  model_t m10, m1;

  argmax_layer #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
    .clock(clock), .reset(reset), .input_ready(ir10), .inputs(in10),
    .index(idx10), .max_value(val10), .output_ready(rdy10), .busy(busy10)
  );

  argmax_layer #(.DATA_WIDTH(DW), .NUM_INPUTS(1)) dut1 (
    .clock(clock), .reset(reset), .input_ready(ir1), .inputs(in1),
    .index(idx1), .max_value(val1), .output_ready(rdy1), .busy(busy1)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t r;
    r.remaining = 0;
    r.ready     = 1'b0;
    r.busy      = 1'b0;
    r.idx       = 0;
    r.val       = '0;
    r.pend_idx  = 0;
    r.pend_val  = '0;
    return r;
  endfunction

  // One clock edge of a layer with n scores: a vector accepted while idle
  // shows its argmax n edges later (the accepting edge counts as the first);
  // the result stays up until the request level is released.
  function automatic model_t model_step(model_t m, bit req, score_arr_t v, int n);
    model_t r;
    r = m;
    if (r.remaining > 0) begin
      r.remaining--;
      if (r.remaining == 0) begin
        r.busy  = 1'b0;
        r.ready = 1'b1;
        r.idx   = r.pend_idx;
        r.val   = r.pend_val;
      end
    end else if (r.ready) begin
      if (!req) r.ready = 1'b0;
    end else if (req) begin
      r.pend_idx = 0;
      r.pend_val = v[0];
      for (int i = 1; i < n; i++) begin
        if (v[i] > r.pend_val) begin
          r.pend_val = v[i];
          r.pend_idx = i;
        end
      end
      r.remaining = n - 1;
      if (n == 1) begin
        r.ready = 1'b1;
        r.idx   = r.pend_idx;
        r.val   = r.pend_val;
      end else begin
        r.busy = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) in1_ext[i] = '0;
    in1_ext[0] = in1[0];
  end

  // Reference model, advanced on the same edges as the design.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m10 <= model_reset();
      m1  <= model_reset();
    end else begin
      m10 <= model_step(m10, ir10, in10, N);
      m1  <= model_step(m1, ir1, in1_ext, 1);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    #1;
    if (cmp_en) begin
      check("rdy10",  rdy10,  m10.ready);
      check("busy10", busy10, m10.busy);
      check("idx10",  idx10,  m10.idx);
      check("val10",  val10,  m10.val);
      check("rdy1",   rdy1,   m1.ready);
      check("busy1",  busy1,  m1.busy);
      check("idx1",   idx1,   m1.idx);
      check("val1",   val1,   m1.val);
    end
  end

  task automatic present10(input score_arr_t v);
    in10 = v;
    ir10 = 1'b1;
  endtask

  // Counts edges from the request until the result flag rises.
  task automatic wait_ready10(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (rdy10 === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("ready10_seen", rdy10, 1);
  endtask

  task automatic drop10();
    ir10 = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    score_arr_t vec_a, vec_b, vec_c, sat;
    int lat;

    vec_a = '{3, -1, 7, 2, 9, 0, 9, -5, 1, 4};
    vec_b = '{-8, -3, -12, -3, -100, -50, -7, -9, -4, -6};
    vec_c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
    for (int i = 0; i < N; i++) begin
      in10[i] = '0;
      sat[i]  = 32'sh7FFF_FFFF;
    end
    in1[0] = '0;

    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    cmp_en = 1'b1;

    // Reset in the middle of a scan discards everything.
    @(negedge clock);
    present10(vec_a);
    repeat (3) @(negedge clock);
    check("busy_mid_scan", busy10, 1);
    reset = 1'b0;
    #1;
    check("rst_rdy",  rdy10,  0);
    check("rst_busy", busy10, 0);
    check("rst_idx",  idx10,  0);
    check("rst_val",  val10,  0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Same vector again with the request still held; tie 4/6 goes to 4.
    wait_ready10(lat);
    check("latency_a", lat, 10);
    check("idx_a", idx10, 4);
    check("val_a", val10, 9);

    // A held request level must not start a second scan.
    repeat (30) @(negedge clock);
    check("hold_rdy",  rdy10,  1);
    check("hold_busy", busy10, 0);
    drop10();
    check("drop_rdy", rdy10, 0);
    check("drop_idx", idx10, 4);
    check("drop_val", val10, 9);

    // All-negative scores with a tie at the maximum.
    present10(vec_b);
    wait_ready10(lat);
    check("latency_b", lat, 10);
    check("idx_b", idx10, 1);
    check("val_b", val10, -3);
    drop10();

    // Upstream changes during the scan must not leak in.
    present10(vec_c);
    repeat (2) @(negedge clock);
    in10 = sat;
    wait_ready10(lat);
    check("idx_c", idx10, 9);
    check("val_c", val10, 5);
    drop10();

    // Single-input build: result on the accepting edge, never busy.
    in1[0] = -42;
    ir1    = 1'b1;
    @(negedge clock);
    check("n1_rdy",  rdy1,  1);
    check("n1_busy", busy1, 0);
    check("n1_idx",  idx1,  0);
    check("n1_val",  val1,  -42);
    repeat (3) @(negedge clock);
    ir1 = 1'b0;
    @(negedge clock);
    check("n1_drop_rdy", rdy1, 0);
    check("n1_drop_val", val1, -42);

    // Random vectors: full range, narrow range (many ties), extremes.
    for (int t = 0; t < 24; t++) begin
      score_arr_t v;
      for (int i = 0; i < N; i++) begin
        int r;
        case (t % 3)
          0: v[i] = $urandom();
          1: begin
            r    = $urandom_range(0, 6);
            v[i] = r - 3;
          end
          default: begin
            r = $urandom_range(0, 3);
            case (r)
              0: v[i] = 32'sh8000_0000;
              1: v[i] = 32'sh7FFF_FFFF;
              2: v[i] = 0;
              default: v[i] = -1;
            endcase
          end
        endcase
      end
      in1[0] = $urandom();
      ir1    = 1'b1;
      present10(v);
      wait_ready10(lat);
      check("latency_rand", lat, 10);
      ir1 = 1'b0;
      drop10();
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
